iter_divider: RTL
=================

ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 Parameter: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 run  input  1  divide request from CPU execute stage; held high until stall deasserts.
REQ-005 u  input  1  1 = unsigned dividend; 0 = signed (two's-complement) dividend; sampled at start only.
REQ-006 x  input  32  dividend; sampled at start only.
REQ-007 y  input  32  divisor, always treated as unsigned in both modes; sampled at start only.
REQ-008 stall  output  1  combinational; high while a requested division is not yet complete.
REQ-009 quot  output  32  quotient register.
REQ-010 rem  output  32  remainder register.

Function
REQ-011 States SHALL be IDLE, BUSY, FIX, DONE, plus a 5-bit iteration counter.
REQ-012 stall SHALL equal run & (state != DONE).
REQ-013 IDLE with run=1 at an edge: latch u, y; latch |x| (x if u=1 or x[31]=0, else -x mod 2^32); latch neg = ~u & x[31]; clear partial remainder; counter=0; go BUSY.
REQ-014 IDLE with run=0: remain IDLE; quot/rem hold.
REQ-015 BUSY: one restoring-division step per cycle, MSB first: shift partial remainder left 1 with next dividend bit; if result >= y (33-bit compare), subtract y and set quotient bit, else clear it.
REQ-016 BUSY SHALL last exactly 32 cycles (counter 0..31), then go FIX.
REQ-017 FIX: if neg=0, quot=q_mag, rem=r_mag; if neg=1 and r_mag=0, quot=-q_mag, rem=0; if neg=1 and r_mag!=0, quot=~q_mag, rem=y-r_mag (floor division, 0<=rem<y); go DONE.
REQ-018 Quotient arithmetic SHALL wrap mod 2^32 (x=0x80000000, y=1, u=0 -> quot=0x80000000).
REQ-019 y=0: quot=0xFFFFFFFF, rem=x (original, unmodified), all modes; same latency as any other division.
REQ-020 DONE: lasts exactly one cycle (stall=0 there), then IDLE unconditionally.
REQ-021 Latency: run rising in cycle 0 -> stall high cycles 0..33 (34 cycles), low in cycle 34, quot/rem valid from cycle 34 and held until the next FIX.
REQ-022 Back-to-back: run held high through DONE -> IDLE in cycle 35 restarts with operands present in cycle 35; stall high again in cycle 35.
REQ-023 Changes on x, y, u or run=0 during BUSY/FIX SHALL not alter the in-flight result; run dropping mid-operation does not abort it (result still written, stall=0 since run=0).
REQ-024 quot/rem SHALL change only in FIX or on reset.

Reset
REQ-025 rst=1 at an edge: state=IDLE, counter=0, quot=0, rem=0, internal registers 0; rst overrides any other transition.
REQ-026 Reset mid-operation SHALL abort the division with no result written; first cycle after reset stall=run.
REQ-027 rst held high: state stays IDLE, stall=run combinationally, no operand capture.

Verification
REQ-028 u=1, x=100, y=7, run held -> stall high exactly 34 cycles; quot=14, rem=2.
REQ-029 u=0, x=0xFFFFFFF9 (-7), y=2 -> quot=0xFFFFFFFC (-4), rem=1; then x=0xFFFFFFF8 (-8), y=2 -> quot=0xFFFFFFFC, rem=0.
REQ-030 u=1, x=0x12345678, y=0 -> quot=0xFFFFFFFF, rem=0x12345678 after 34 stall cycles.
REQ-031 Back-to-back: run held high, x=0xFFFFFFFF,y=1,u=1 then x=0x80000000,y=1,u=0 presented in cycle 35 -> first quot=0xFFFFFFFF rem=0, second quot=0x80000000 rem=0; stall low only in cycles 34 and 69.
REQ-032 Operand change: x/y toggled every cycle during BUSY after starting x=100,y=7,u=1 -> quot=14, rem=2.
REQ-033 rst pulsed in BUSY iteration 10 -> quot=0, rem=0, stall=run next cycle; subsequent u=1, x=1000, y=10 -> quot=100, rem=0.

Source files
------------

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: 32-bit dividend (signed or unsigned) by an
// unsigned 32-bit divisor, floor semantics for negative dividends.
module iter_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        u,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        stall,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_r;
  logic [4:0]  cnt_r;
  logic        neg_r;
  logic [31:0] x_r;
  logic [31:0] y_r;
  logic [31:0] dvd_r;
  logic [31:0] pr_r;
  logic [31:0] q_r;

  logic [32:0] shift_s;
  logic [31:0] diff_s;
  logic        qbit_s;
  logic [31:0] abs_x_s;

  assign stall = run & (state_r != DONE);

  // One restoring step plus dividend magnitude for the start of an operation
  always_comb begin
    shift_s = {pr_r, dvd_r[31]};
    diff_s  = shift_s[31:0];
    qbit_s  = 1'b0;
    if (shift_s >= {1'b0, y_r}) begin
      diff_s = shift_s[31:0] - y_r;
      qbit_s = 1'b1;
    end else begin
      diff_s = shift_s[31:0];
      qbit_s = 1'b0;
    end
    if (u | ~x[31]) begin
      abs_x_s = x;
    end else begin
      abs_x_s = 32'd0 - x;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      neg_r   <= 1'b0;
      x_r     <= 32'd0;
      y_r     <= 32'd0;
      dvd_r   <= 32'd0;
      pr_r    <= 32'd0;
      q_r     <= 32'd0;
      quot    <= 32'd0;
      rem     <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (run) begin
            x_r     <= x;
            y_r     <= y;
            dvd_r   <= abs_x_s;
            neg_r   <= ~u & x[31];
            pr_r    <= 32'd0;
            q_r     <= 32'd0;
            cnt_r   <= 5'd0;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          pr_r  <= diff_s;
          q_r   <= {q_r[30:0], qbit_s};
          dvd_r <= {dvd_r[30:0], 1'b0};
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= FIX;
          end else begin
            state_r <= BUSY;
          end
        end
        FIX: begin
          // Divide-by-zero reports the untouched dividend in every mode
          if (y_r == 32'd0) begin
            quot <= 32'hFFFF_FFFF;
            rem  <= x_r;
          end else if (!neg_r) begin
            quot <= q_r;
            rem  <= pr_r;
          end else if (pr_r == 32'd0) begin
            quot <= 32'd0 - q_r;
            rem  <= 32'd0;
          end else begin
            quot <= ~q_r;
            rem  <= y_r - pr_r;
          end
          state_r <= DONE;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
